// File: rtl/alu_decode_stage_if.sv
// Purpose: bundles the upstream instruction handshake and the downstream decoded ALU control of alu_decode_stage.
// Latency: none (signal bundle only).
// Backpressure: upstream is gated by o_ready and downstream by i_ready; slave = decode stage, master = surrounding pipeline.
// Ports: i_valid/o_ready/i_inst (upstream), o_valid/i_ready (downstream), decoded control fields, o_illegal_cnt.
interface alu_decode_stage_if #(
    parameter int CNT_W = 8
);
    logic             i_valid;
    logic             o_ready;
    logic [31:0]      i_inst;
    logic             o_valid;
    logic             i_ready;
    logic [1:0]       o_unit;
    logic [1:0]       o_logic_mode;
    logic             o_sub;
    logic [1:0]       o_shift_mode;
    logic             o_cmp_unsigned;
    logic             o_use_imm;
    logic [31:0]      o_imm;
    logic [4:0]       o_rd;
    logic [4:0]       o_rs1;
    logic [4:0]       o_rs2;
    logic             o_illegal;
    logic [CNT_W-1:0] o_illegal_cnt;

    modport slave (
        input  i_valid, i_inst, i_ready,
        output o_ready, o_valid, o_unit, o_logic_mode, o_sub, o_shift_mode,
               o_cmp_unsigned, o_use_imm, o_imm, o_rd, o_rs1, o_rs2,
               o_illegal, o_illegal_cnt
    );

    modport master (
        output i_valid, i_inst, i_ready,
        input  o_ready, o_valid, o_unit, o_logic_mode, o_sub, o_shift_mode,
               o_cmp_unsigned, o_use_imm, o_imm, o_rd, o_rs1, o_rs2,
               o_illegal, o_illegal_cnt
    );
endinterface

// File: rtl/alu_decode_stage.sv
// Purpose: decodes RV32I OP / OP-IMM instructions into registered integer ALU control.
// Latency: 1 cycle from accept to o_valid.
// Backpressure: o_ready = !o_valid || i_ready; all outputs hold while o_valid && !i_ready.
// Ports: i_clk, i_rst_n (async active-low), i_flush (sync drop), bus (alu_decode_stage_if.slave).
module alu_decode_stage #(
    parameter int CNT_W = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_flush,
    alu_decode_stage_if.slave    bus
);

    localparam logic [6:0] OPC_R  = 7'b0110011;
    localparam logic [6:0] OPC_I  = 7'b0010011;
    localparam logic [6:0] F7_STD = 7'b0000000;
    localparam logic [6:0] F7_ALT = 7'b0100000;

    localparam logic [1:0] UNIT_ADD   = 2'd0;
    localparam logic [1:0] UNIT_LOGIC = 2'd1;
    localparam logic [1:0] UNIT_SHIFT = 2'd2;
    localparam logic [1:0] UNIT_CMP   = 2'd3;

    localparam logic [1:0] LM_AND  = 2'd0;
    localparam logic [1:0] LM_OR   = 2'd1;
    localparam logic [1:0] LM_XOR  = 2'd2;
    localparam logic [1:0] LM_NONE = 2'd3;

    localparam logic [1:0] SH_SLL = 2'd0;
    localparam logic [1:0] SH_SRL = 2'd1;
    localparam logic [1:0] SH_SRA = 2'd2;

    typedef struct packed {
        logic [1:0]  unit;
        logic [1:0]  logic_mode;
        logic        sub;
        logic [1:0]  shift_mode;
        logic        cmp_unsigned;
        logic        use_imm;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        illegal;
    } dec_t;

    dec_t             dec_d;
    dec_t             dec_q;
    logic             vld_q;
    logic [CNT_W-1:0] cnt_q;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       is_r;
    logic       is_i;
    logic       is_shift;
    logic       legal;
    logic       accept;

    assign opcode   = bus.i_inst[6:0];
    assign funct3   = bus.i_inst[14:12];
    assign funct7   = bus.i_inst[31:25];
    assign is_r     = (opcode == OPC_R);
    assign is_i     = (opcode == OPC_I);
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    // For OP-IMM, inst[31:25] is immediate payload except on shifts, where
    // it selects SRL/SRA and must otherwise be zero.
    always_comb begin
        legal = 1'b0;
        if (is_r) begin
            legal = (funct7 == F7_STD) ||
                    ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        end else if (is_i) begin
            if (funct3 == 3'b001)
                legal = (funct7 == F7_STD);
            else if (funct3 == 3'b101)
                legal = (funct7 == F7_STD) || (funct7 == F7_ALT);
            else
                legal = 1'b1;
        end
    end

    // Illegal words produce an all-zero control bundle apart from the
    // "no logic op" marker, so nothing downstream sees stray fields.
    always_comb begin
        dec_d            = '0;
        dec_d.logic_mode = LM_NONE;
        if (!legal) begin
            dec_d.illegal = 1'b1;
        end else begin
            dec_d.rd      = bus.i_inst[11:7];
            dec_d.rs1     = bus.i_inst[19:15];
            dec_d.rs2     = is_i ? 5'd0 : bus.i_inst[24:20];
            dec_d.use_imm = is_i;
            case (funct3)
                3'b000: begin
                    dec_d.unit = UNIT_ADD;
                    dec_d.sub  = is_r && (funct7 == F7_ALT);
                end
                3'b001: begin
                    dec_d.unit       = UNIT_SHIFT;
                    dec_d.shift_mode = SH_SLL;
                end
                3'b101: begin
                    dec_d.unit       = UNIT_SHIFT;
                    dec_d.shift_mode = (funct7 == F7_ALT) ? SH_SRA : SH_SRL;
                end
                3'b010: dec_d.unit = UNIT_CMP;
                3'b011: begin
                    dec_d.unit         = UNIT_CMP;
                    dec_d.cmp_unsigned = 1'b1;
                end
                3'b100: begin
                    dec_d.unit       = UNIT_LOGIC;
                    dec_d.logic_mode = LM_XOR;
                end
                3'b110: begin
                    dec_d.unit       = UNIT_LOGIC;
                    dec_d.logic_mode = LM_OR;
                end
                default: begin
                    dec_d.unit       = UNIT_LOGIC;
                    dec_d.logic_mode = LM_AND;
                end
            endcase
            if (is_i) begin
                dec_d.imm = is_shift ? {27'd0, bus.i_inst[24:20]}
                                     : {{20{bus.i_inst[31]}}, bus.i_inst[31:20]};
            end
        end
    end

    assign bus.o_ready = !vld_q || bus.i_ready;
    // Flush blocks a same-cycle accept so a dropped illegal is never counted.
    assign accept      = bus.i_valid && bus.o_ready && !i_flush;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_q            <= 1'b0;
            dec_q            <= '0;
            dec_q.logic_mode <= LM_NONE;
            cnt_q            <= '0;
        end else if (i_flush) begin
            vld_q <= 1'b0;
        end else if (accept) begin
            vld_q <= 1'b1;
            dec_q <= dec_d;
            if (dec_d.illegal && !(&cnt_q))
                cnt_q <= cnt_q + 1'b1;
        end else if (bus.i_ready) begin
            vld_q <= 1'b0;
        end
    end

    assign bus.o_valid        = vld_q;
    assign bus.o_unit         = dec_q.unit;
    assign bus.o_logic_mode   = dec_q.logic_mode;
    assign bus.o_sub          = dec_q.sub;
    assign bus.o_shift_mode   = dec_q.shift_mode;
    assign bus.o_cmp_unsigned = dec_q.cmp_unsigned;
    assign bus.o_use_imm      = dec_q.use_imm;
    assign bus.o_imm          = dec_q.imm;
    assign bus.o_rd           = dec_q.rd;
    assign bus.o_rs1          = dec_q.rs1;
    assign bus.o_rs2          = dec_q.rs2;
    assign bus.o_illegal      = dec_q.illegal;
    assign bus.o_illegal_cnt  = cnt_q;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Purpose: directed-vector bench for alu_decode_stage with hand-computed expectations.
// Latency: checks sampled 1 time unit after the rising edge.
// Backpressure: exercises stalls, flush and reset during a stall.
module tb_alu_decode_stage;

    logic i_clk;
    logic i_rst_n;
    logic i_flush;

    int n_tests;
    int n_fail;

    alu_decode_stage_if #(.CNT_W(8)) bus ();

    alu_decode_stage #(.CNT_W(8)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (i_flush),
        .bus     (bus.slave)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        i_rst_n     = 1'b0;
        i_flush     = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_inst  = 32'h0;
        bus.i_ready = 1'b1;
        tick();
        tick();

        check("rst_valid", 32'(bus.o_valid), 0);
        check("rst_lmode", 32'(bus.o_logic_mode), 3);
        check("rst_unit",  32'(bus.o_unit), 0);
        check("rst_imm",   bus.o_imm, 0);
        check("rst_cnt",   32'(bus.o_illegal_cnt), 0);
        check("rst_ready", 32'(bus.o_ready), 1);

        i_rst_n = 1'b1;
        tick();

        // AND x3,x1,x2
        bus.i_valid = 1'b1;
        bus.i_inst  = 32'h0020F1B3;
        tick();
        check("and_valid", 32'(bus.o_valid), 1);
        check("and_unit",  32'(bus.o_unit), 1);
        check("and_lmode", 32'(bus.o_logic_mode), 0);
        check("and_rd",    32'(bus.o_rd), 3);
        check("and_rs1",   32'(bus.o_rs1), 1);
        check("and_rs2",   32'(bus.o_rs2), 2);
        check("and_uimm",  32'(bus.o_use_imm), 0);
        check("and_ill",   32'(bus.o_illegal), 0);

        // XORI x5,x6,-1
        bus.i_inst = 32'hFFF34293;
        tick();
        check("xori_unit",  32'(bus.o_unit), 1);
        check("xori_lmode", 32'(bus.o_logic_mode), 2);
        check("xori_uimm",  32'(bus.o_use_imm), 1);
        check("xori_imm",   bus.o_imm, 32'hFFFFFFFF);
        check("xori_rd",    32'(bus.o_rd), 5);
        check("xori_rs1",   32'(bus.o_rs1), 6);
        check("xori_rs2",   32'(bus.o_rs2), 0);

        // Stall 3 cycles with SUB x3,x1,x2 waiting upstream
        bus.i_ready = 1'b0;
        bus.i_inst  = 32'h402081B3;
        #1;
        check("stall_ready", 32'(bus.o_ready), 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_valid", 32'(bus.o_valid), 1);
            check("stall_imm",   bus.o_imm, 32'hFFFFFFFF);
            check("stall_lmode", 32'(bus.o_logic_mode), 2);
            check("stall_rdy",   32'(bus.o_ready), 0);
        end
        bus.i_ready = 1'b1;
        #1;
        check("unstall_ready", 32'(bus.o_ready), 1);
        tick();
        check("sub_unit",  32'(bus.o_unit), 0);
        check("sub_sub",   32'(bus.o_sub), 1);
        check("sub_lmode", 32'(bus.o_logic_mode), 3);
        check("sub_rd",    32'(bus.o_rd), 3);
        check("sub_rs2",   32'(bus.o_rs2), 2);
        check("sub_imm",   bus.o_imm, 0);

        // SRAI x4,x5,7
        bus.i_inst = 32'h4072D213;
        tick();
        check("srai_unit",  32'(bus.o_unit), 2);
        check("srai_smode", 32'(bus.o_shift_mode), 2);
        check("srai_imm",   bus.o_imm, 7);
        check("srai_rs1",   32'(bus.o_rs1), 5);
        check("srai_rd",    32'(bus.o_rd), 4);
        check("srai_ill",   32'(bus.o_illegal), 0);

        // SLTU x7,x8,x9
        bus.i_inst = 32'h009433B3;
        tick();
        check("sltu_unit", 32'(bus.o_unit), 3);
        check("sltu_uns",  32'(bus.o_cmp_unsigned), 1);
        check("sltu_rs2",  32'(bus.o_rs2), 9);

        // ADDI x1,x2,-2048 (imm bit 30 clear, no subtract on I-type)
        bus.i_inst = 32'h80010093;
        tick();
        check("addi_unit", 32'(bus.o_unit), 0);
        check("addi_sub",  32'(bus.o_sub), 0);
        check("addi_imm",  bus.o_imm, 32'hFFFFF800);

        // Illegal: AND with funct7=0100000
        bus.i_inst = 32'h4020F1B3;
        tick();
        check("ill_valid", 32'(bus.o_valid), 1);
        check("ill_flag",  32'(bus.o_illegal), 1);
        check("ill_lmode", 32'(bus.o_logic_mode), 3);
        check("ill_unit",  32'(bus.o_unit), 0);
        check("ill_rd",    32'(bus.o_rd), 0);
        check("ill_cnt",   32'(bus.o_illegal_cnt), 1);

        // Illegal: load opcode
        bus.i_inst = 32'h00000003;
        tick();
        check("badop_ill", 32'(bus.o_illegal), 1);
        check("badop_cnt", 32'(bus.o_illegal_cnt), 2);

        // Flush wins over a same-cycle accept of an illegal
        i_flush    = 1'b1;
        bus.i_inst = 32'h4020F1B3;
        tick();
        i_flush = 1'b0;
        check("flush_valid", 32'(bus.o_valid), 0);
        check("flush_cnt",   32'(bus.o_illegal_cnt), 2);

        // 300 illegals back-to-back saturate the counter
        for (int k = 0; k < 300; k++) tick();
        check("sat_cnt", 32'(bus.o_illegal_cnt), 255);

        // No accept with ready high drops valid
        bus.i_valid = 1'b0;
        tick();
        check("idle_valid", 32'(bus.o_valid), 0);
        check("idle_cnt",   32'(bus.o_illegal_cnt), 255);

        // Reset asserted mid-stall takes effect without a clock edge
        bus.i_valid = 1'b1;
        bus.i_inst  = 32'h0020F1B3;
        tick();
        bus.i_ready = 1'b0;
        bus.i_inst  = 32'hFFF34293;
        tick();
        check("pre_rst_valid", 32'(bus.o_valid), 1);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(bus.o_valid), 0);
        check("arst_lmode", 32'(bus.o_logic_mode), 3);
        check("arst_unit",  32'(bus.o_unit), 0);
        check("arst_rd",    32'(bus.o_rd), 0);
        check("arst_cnt",   32'(bus.o_illegal_cnt), 0);
        bus.i_valid = 1'b0;
        tick();
        i_rst_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
